// File: rtl/vga_console_pkg.sv
// Shared definitions for the text console: control codes, FSM encoding, char classifier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_console_pkg;

    localparam logic [7:0] CC_BS    = 8'h08;
    localparam logic [7:0] CC_LF    = 8'h0A;
    localparam logic [7:0] CC_FF    = 8'h0C;
    localparam logic [7:0] CC_CR    = 8'h0D;
    localparam logic [7:0] CC_SPACE = 8'h20;
    localparam logic [7:0] CC_DEL   = 8'h7F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_CLRLINE = 2'd2
    } state_t;

    // Glyph codes are everything except the C0 control block and DEL.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CC_SPACE) && (c != CC_DEL);
    endfunction

endpackage

// File: rtl/vga_text_console_if.sv
// Bundles the character input stream (valid/ready) and the VRAM write port.
// Latency: n/a (wires only).
// Backpressure: in_ready from the console gates the producer; the VRAM port has none.
// master = producer/observer side, slave = console side.
interface vga_text_console_if #(
    parameter int ADDR_W = 12,
    parameter int ATTR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_char;
    logic [ATTR_W-1:0] in_attr;
    logic              vga_we;
    logic [ADDR_W-1:0] vga_addr;
    logic [ATTR_W+7:0] vga_data;

    modport master (
        output in_valid, in_char, in_attr,
        input  in_ready, vga_we, vga_addr, vga_data
    );

    modport slave (
        input  in_valid, in_char, in_attr,
        output in_ready, vga_we, vga_addr, vga_data
    );
endinterface

// File: rtl/vga_sweep_counter.sv
// Emits len ascending addresses from start_addr, one per cycle, for blanking sweeps.
// Latency: first address presented combinationally in the start cycle; done flags the last one.
// Backpressure: none; start is ignored while a sweep is active.
// Ports: clk/rst, start + start_addr + len in; addr/valid/done/active out.
module vga_sweep_counter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              done,
    output logic              active
);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);

    logic              active_q, active_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W:0]   rem_sel;

    // The start cycle already issues start_addr so the owner FSM loses no cycle.
    always_comb begin
        valid    = active_q | start;
        addr     = active_q ? cur_q : start_addr;
        rem_sel  = active_q ? rem_q : len;
        done     = valid && (rem_sel == LEN_ONE);
        active_d = valid && !done;
        cur_d    = addr + ADDR_ONE;
        rem_d    = rem_sel - LEN_ONE;
        active   = active_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cur_q    <= '0;
            rem_q    <= '0;
        end else begin
            active_q <= active_d;
            cur_q    <= cur_d;
            rem_q    <= rem_d;
        end
    end
endmodule

// File: rtl/vga_text_console.sv
// Terminal-style writer: character stream -> VRAM writes with cursor, wrap, CR/LF/BS/FF.
// Latency: char accepted at cycle N drives vga_we/addr/data at N+1 for one cycle.
// Backpressure: in_ready only in IDLE; low for the whole clear/line-clear sweep.
// Ports: clk/rst, bus (slave: in_* stream, vga_* write port), cursor_col/row, busy.
module vga_text_console
    import vga_console_pkg::*;
#(
    parameter int              COLS         = 80,
    parameter int              ROWS         = 30,
    parameter int              ADDR_W       = 12,
    parameter int              ATTR_W       = 8,
    parameter logic [ATTR_W-1:0] DEFAULT_ATTR = 'h07,
    parameter bit              CLEAR_ON_RST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    vga_text_console_if.slave        bus,
    output logic [$clog2(COLS)-1:0]  cursor_col,
    output logic [$clog2(ROWS)-1:0]  cursor_row,
    output logic                     busy
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   SCREEN_LEN = (ADDR_W+1)'(COLS * ROWS);
    localparam logic [ADDR_W:0]   LINE_LEN   = (ADDR_W+1)'(COLS);
    localparam logic [CW-1:0]     COL_MAX    = CW'(COLS - 1);
    localparam logic [RW-1:0]     ROW_MAX    = RW'(ROWS - 1);
    localparam logic [ATTR_W+7:0] BLANK      = {DEFAULT_ATTR, CC_SPACE};

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [ADDR_W-1:0]   rb_q, rb_d;        // row_q * COLS, tracked incrementally
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ATTR_W+7:0]   data_q, data_d;

    logic                in_ready;
    logic                accept;
    logic [RW-1:0]       step_row;
    logic [ADDR_W-1:0]   step_rb;
    logic                step_wrap;

    logic                sw_start;
    logic [ADDR_W-1:0]   sw_start_addr;
    logic [ADDR_W:0]     sw_len;
    logic [ADDR_W-1:0]   sw_addr;
    logic                sw_valid;
    logic                sw_done;
    logic                sw_active;

    vga_sweep_counter #(.ADDR_W(ADDR_W)) u_sweep (
        .clk        (clk),
        .rst        (rst),
        .start      (sw_start),
        .start_addr (sw_start_addr),
        .len        (sw_len),
        .addr       (sw_addr),
        .valid      (sw_valid),
        .done       (sw_done),
        .active     (sw_active)
    );

    // Gated by rst so nothing is taken in the reset cycle, even with CLEAR_ON_RST=0.
    assign in_ready     = (state_q == ST_IDLE) && !rst;
    assign accept       = bus.in_valid && in_ready;
    assign bus.in_ready = in_ready;
    assign bus.vga_we   = we_q;
    assign bus.vga_addr = addr_q;
    assign bus.vga_data = data_q;
    assign cursor_col   = col_q;
    assign cursor_row   = row_q;
    assign busy         = (state_q != ST_IDLE);

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        rb_d          = rb_q;
        we_d          = 1'b0;
        addr_d        = addr_q;
        data_d        = data_q;
        sw_start      = 1'b0;
        sw_start_addr = rb_q;
        sw_len        = LINE_LEN;

        // Shared "move to next row" outcome for LF and end-of-line wrap.
        if (row_q == ROW_MAX) begin
            step_row  = '0;
            step_rb   = '0;
            step_wrap = 1'b1;
        end else begin
            step_row  = row_q + RW'(1);
            step_rb   = rb_q + COLS_A;
            step_wrap = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(bus.in_char)) begin
                        we_d   = 1'b1;
                        addr_d = rb_q + ADDR_W'(col_q);
                        data_d = {bus.in_attr, bus.in_char};
                        if (col_q == COL_MAX) begin
                            col_d = '0;
                            row_d = step_row;
                            rb_d  = step_rb;
                            if (step_wrap) state_d = ST_CLRLINE;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        case (bus.in_char)
                            CC_CR: col_d = '0;
                            CC_LF: begin
                                col_d = '0;
                                row_d = step_row;
                                rb_d  = step_rb;
                                if (step_wrap) state_d = ST_CLRLINE;
                            end
                            CC_BS: begin
                                if (col_q != '0) begin
                                    col_d  = col_q - CW'(1);
                                    we_d   = 1'b1;
                                    addr_d = rb_q + ADDR_W'(col_q) - ADDR_ONE;
                                    data_d = BLANK;
                                end else if (row_q != '0) begin
                                    // Last cell of the previous row is rb_q - 1.
                                    col_d  = COL_MAX;
                                    row_d  = row_q - RW'(1);
                                    rb_d   = rb_q - COLS_A;
                                    we_d   = 1'b1;
                                    addr_d = rb_q - ADDR_ONE;
                                    data_d = BLANK;
                                end
                            end
                            CC_FF:   state_d = ST_CLEAR;
                            default: ;
                        endcase
                    end
                end
            end

            ST_CLEAR: begin
                sw_start_addr = '0;
                sw_len        = SCREEN_LEN;
                sw_start      = !sw_active;
                if (sw_valid) begin
                    we_d   = 1'b1;
                    addr_d = sw_addr;
                    data_d = BLANK;
                end
                if (sw_done) begin
                    state_d = ST_IDLE;
                    col_d   = '0;
                    row_d   = '0;
                    rb_d    = '0;
                end
            end

            ST_CLRLINE: begin
                // rb_q already points at the row the cursor moved onto.
                sw_start = !sw_active;
                if (sw_valid) begin
                    we_d   = 1'b1;
                    addr_d = sw_addr;
                    data_d = BLANK;
                end
                if (sw_done) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            rb_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            rb_q    <= rb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end
endmodule
